// File: rtl/btn_pulse_arb_pkg.sv
// ----------------------------------------------------------------------------
// btn_pulse_arb_pkg
// Shared state encodings for the button pulse arbiter.
//   btn_state_e : per-button press FSM (S_IDLE, S_PULSE, S_WAIT)
//   arb_state_e : round-robin arbiter FSM (A_IDLE, A_GRANT, A_DONE)
//   ST_W        : width of both state encodings (encoding 3 is illegal)
// ----------------------------------------------------------------------------
package btn_pulse_arb_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } btn_state_e;

  typedef enum logic [ST_W-1:0] {
    A_IDLE  = 2'd0,
    A_GRANT = 2'd1,
    A_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/btn_pulse_fsm.sv
// ----------------------------------------------------------------------------
// btn_pulse_fsm
// Converts one button level into a single-cycle pulse per press, however long
// the button is held. A new pulse needs the button to be released first.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active-low
//   btn   : button level, 1 = pressed, already synchronous to clk
//   pulse : high for exactly one cycle after a press is sampled
// ----------------------------------------------------------------------------
module btn_pulse_fsm
  import btn_pulse_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  btn_state_e r_state;
  btn_state_e w_state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (btn) w_state_nxt = S_PULSE;
      S_PULSE: w_state_nxt = S_WAIT;
      S_WAIT:  if (!btn) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pulse = (r_state == S_PULSE);

endmodule

// File: rtl/btn_pulse_arbiter.sv
// ----------------------------------------------------------------------------
// btn_pulse_arbiter
// Shares one valid/ready event channel among N_REQ push-buttons. Each press
// becomes one pending request; a round-robin arbiter grants pending requests
// one at a time and reports the button index.
// Parameters:
//   N_REQ : number of buttons (2..16); IDX_W = $clog2(N_REQ) is derived
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-low
//   btn        : raw button levels, synchronous to clk
//   out_ready  : consumer accepts the current event
//   out_valid  : an event is presented
//   out_idx    : granted button index, meaningful while out_valid = 1
//   pend       : pending-request vector
//   lost       : sticky, a press hit an already pending request
//   state_test : arbiter state, only when BTN_PULSE_ARB_STATE_TEST_EN is defined
// ----------------------------------------------------------------------------
module btn_pulse_arbiter
  import btn_pulse_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] btn,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pend,
  output logic             lost
`ifdef BTN_PULSE_ARB_STATE_TEST_EN
  ,
  output logic [ST_W-1:0]  state_test
`endif
);

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_clr;
  logic             w_hs;
  logic [N_REQ-1:0] r_pend;
  logic             r_lost;
  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;

  // First set bit of req at or above ptr, wrapping from N_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        pick  = IDX_W'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_btn
    btn_pulse_fsm u_fsm (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[g]),
      .pulse (w_req[g])
    );
  end

  assign w_hs = (r_state == A_GRANT) && out_ready;

  always_comb begin
    w_clr = '0;
    if (w_hs) w_clr[r_idx] = 1'b1;
  end

  // A set landing on the same cycle as its clear wins, so that press is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_lost <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_req;
      if (|(w_req & r_pend & ~w_clr)) r_lost <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= A_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      A_IDLE: begin
        if (|r_pend) begin
          w_state_nxt = A_GRANT;
          w_idx_nxt   = rr_pick(r_pend, r_ptr);
        end
      end
      A_GRANT: begin
        if (out_ready) begin
          w_state_nxt = A_DONE;
          w_ptr_nxt   = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
        end
      end
      // One-cycle bubble so the cleared pend bit is visible before the next pick.
      A_DONE:  w_state_nxt = A_IDLE;
      default: w_state_nxt = A_IDLE;
    endcase
  end

  assign out_valid = (r_state == A_GRANT);
  assign out_idx   = r_idx;
  assign pend      = r_pend;
  assign lost      = r_lost;

`ifdef BTN_PULSE_ARB_STATE_TEST_EN
  assign state_test = r_state;
`endif

endmodule

// File: doc/btn_pulse_arbiter.md
# btn_pulse_arbiter

Shares one downstream pulse channel among N_REQ push-buttons. Each button feeds a press-to-single-pulse state machine. Each pulse is latched as a pending request. A round-robin scheduler then grants pending requests one at a time through a valid/ready handshake, reporting which button was pressed. It sits between the board button inputs and any consumer that must see exactly one event per press.

## Interface
- N_REQ, 4: number of button inputs, 2..16.
- IDX_W, derived $clog2(N_REQ): width of the index output. Local, not overridable.
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- btn  input  N_REQ  raw button levels, 1 = pressed; already synchronous to clk.
- out_ready  input  1  consumer accepts the current event.
- out_valid  output  1  an event is presented.
- out_idx  output  IDX_W  index of the granted button; meaningful only while out_valid = 1.
- pend  output  N_REQ  pending-request vector.
- lost  output  1  sticky flag: a press was dropped because its request was already pending.
- state_test  output  2  arbiter state; present only with the macro in Configuration.

## Operation
- Reset (rst = 0), applied immediately regardless of clk:
  - all button FSMs go to IDLE;
  - pend = 0, lost = 0, out_valid = 0, out_idx = 0;
  - round-robin pointer = 0; arbiter goes to A_IDLE.
- Per-button FSM, 2-bit encoding:
  - IDLE(0) -> PULSE(1) when btn[i] = 1.
  - PULSE(1) -> WAIT(2) unconditionally.
  - WAIT(2) -> IDLE(0) when btn[i] = 0; stays in WAIT otherwise.
  - Encoding 3 is illegal and recovers to IDLE.
  - req_p[i] = (state == PULSE): exactly one cycle per press, however long the button is held.
- Pending vector:
  - pend[i] is set on req_p[i].
  - pend[i] is cleared when out_valid & out_ready & (out_idx == i).
  - If set and clear happen in the same cycle, set wins: pend[i] stays 1.
  - req_p[i] while pend[i] = 1 and no clear that cycle: the press is dropped and lost is set to 1. lost clears only on reset.
- Arbiter FSM, 2-bit:
  - A_IDLE(0) -> A_GRANT(1) when pend != 0. out_idx is loaded with the first set bit of pend, searching upward from the pointer and wrapping from N_REQ-1 to 0.
  - A_GRANT(1): out_valid = 1 and out_idx is held stable.
  - A_GRANT stays while out_ready = 0.
  - On out_ready = 1: pointer = (out_idx + 1) mod N_REQ, then go to A_DONE(2).
  - A_DONE(2) -> A_IDLE(0) unconditionally. This is a one-cycle bubble; out_valid = 0.
  - Encoding 3 is illegal and recovers to A_IDLE.
- out_valid is registered and equals (state == A_GRANT). It never drops without a handshake except on reset.

## Timing
- btn[i] rises before edge k → req_p[i] high in cycle k..k+1 → pend[i] = 1 after edge k+1 → out_valid = 1 after edge k+2.
- Press-to-valid latency is 2 cycles.
- A handshake at edge m clears pend[out_idx] and out_valid after edge m. The earliest next out_valid is after edge m+2.
- Maximum throughput is one event per 3 cycles.
- Holding out_ready = 1 permanently is legal.
- out_ready is ignored while out_valid = 0.
- Fairness: with all N_REQ requests pending, each index is granted once within N_REQ consecutive grants.

## Configuration
- BTN_PULSE_ARB_STATE_TEST_EN defined: the state_test port exists and carries the arbiter state encoding.
- Macro undefined: the port is absent and the behaviour is otherwise identical.

## Structure
- Package btn_pulse_arb_pkg holds:
  - the button-FSM state constants (S_IDLE, S_PULSE, S_WAIT);
  - the arbiter state constants (A_IDLE, A_GRANT, A_DONE);
  - the 2-bit state width.
- Sub-module btn_pulse_fsm, instantiated N_REQ times via generate: inputs clk, rst, btn; output pulse.
- Pending logic, round-robin search and arbiter FSM live in the top module.

## Test plan
All scenarios use N_REQ = 4 and a 100 ns clock.
- Reset: rst = 0 mid-grant at arbitrary time → out_valid = 0, pend = 0, lost = 0, state_test = 0 immediately, before the next edge.
- Single hold: btn = 4'b0001 held 5 cycles, out_ready = 1 → exactly one out_valid pulse with out_idx = 0, 2 cycles after the sampling edge; pend returns to 0; no second event until release and re-press.
- Backpressure: press btn[2], out_ready = 0 for 4 cycles → out_valid stays 1 and out_idx stays 2 for all 4 cycles; raise out_ready → one handshake; pend[2] = 0.
- Round-robin: press all four buttons simultaneously, out_ready = 1 → out_idx sequence 0,1,2,3, each 3 cycles apart. Then press btn[0] and btn[1] together → grant 0 then 1; the pointer wraps correctly.
- Drop: press btn[1] twice while out_ready = 0 → lost = 1, and only one event for index 1 after out_ready rises.
- Set/clear collision: a new btn[3] pulse lands in the same cycle as the handshake of index 3 → pend[3] stays 1 and a second event with out_idx = 3 follows; lost stays 0.
